mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/lane_prio_enc.sv | 26 ++
 rtl/mem_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mem_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU memory path.
// Contents:
//   OP_LW / OP_SW  - opcodes that the memory sequencer acts on
//   seq_state_t    - memory sequencer FSM states
//   is_mem_op()    - true when an opcode is a load or a store
package gpu_pkg;

    localparam logic [3:0] OP_LW = 4'b0110;
    localparam logic [3:0] OP_SW = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_DONE
    } seq_state_t;

    function automatic logic is_mem_op(input logic [3:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next warp lane to service.
// Ports:
//   req   in  NUM_LANES  lanes still waiting for service
//   idx   out LANE_W     index of the lowest set bit of req (0 when none)
//   valid out 1          at least one bit of req is set
module lane_prio_enc #(
    parameter int NUM_LANES = 16,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    output logic [LANE_W-1:0]    idx,
    output logic                 valid
);

    // Scanning from the top down lets the lowest set bit win the last write.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = LANE_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// Serialises a warp-wide load or store into single-word memory requests.
// A load/store instruction is captured in IDLE; lanes are then serviced in
// ascending lane order. Stores are posted (one request per active lane).
// Loads keep one request outstanding and every pending lane sharing the
// returned address is filled from the same response (coalescing).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   op                instruction opcode (OP_LW / OP_SW act, others ignored)
//   active_mask       lanes taking part in the instruction
//   addr_in, sw_data  per-lane address / store data, lane i at [i*W +: W]
//   lw_out            per-lane load results, lane i at [i*DATA_W +: DATA_W]
//   stall             hold the pipeline while the sequencer is busy
//   done              one-cycle pulse when the instruction has completed
//   mem_req_*         request channel (valid/ready, we, addr, wdata)
//   mem_rsp_*         load response channel (valid, rdata)
module mem_sequencer
    import gpu_pkg::*;
#(
    parameter int NUM_LANES = 16,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  op,
    input  logic [NUM_LANES-1:0]        active_mask,
    input  logic [NUM_LANES*ADDR_W-1:0] addr_in,
    input  logic [NUM_LANES*DATA_W-1:0] sw_data,
    output logic [NUM_LANES*DATA_W-1:0] lw_out,
    output logic                        stall,
    output logic                        done,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_W-1:0]           mem_rdata
);

    seq_state_t state;
    seq_state_t state_next;

    logic [NUM_LANES-1:0] pending;
    logic                 is_store;
    logic [ADDR_W-1:0]    shadow_addr [NUM_LANES];
    logic [DATA_W-1:0]    shadow_data [NUM_LANES];
    logic [ADDR_W-1:0]    cur_addr;
    logic [DATA_W-1:0]    lw_q [NUM_LANES];

    logic [LANE_W-1:0]    cur_lane;
    logic                 lane_valid;
    logic                 req_fire;

    lane_prio_enc #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_prio (
        .req   (pending),
        .idx   (cur_lane),
        .valid (lane_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Request outputs are driven straight from
    // the pending mask and the shadow arrays, which only change on a
    // handshake, so they stay stable while the memory back-pressures.
    // Requests are gated by reset so an aborted operation cannot complete a
    // handshake in the reset cycle itself.
    always_comb begin
        state_next    = state;
        stall         = 1'b0;
        done          = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        req_fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_mem_op(op)) begin
                    stall      = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                stall = 1'b1;
                if (!lane_valid) begin
                    state_next = ST_DONE;
                end else if (!reset) begin
                    mem_req_valid = 1'b1;
                    mem_we        = is_store;
                    mem_addr      = shadow_addr[cur_lane];
                    mem_wdata     = is_store ? shadow_data[cur_lane] : '0;
                    req_fire      = mem_req_ready;
                    if (mem_req_ready && !is_store) begin
                        state_next = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                stall = 1'b1;
                if (mem_rsp_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction capture, lane bookkeeping and load result writeback.
    // A response fills every still-pending lane whose address matches the
    // outstanding one, so duplicate addresses cost a single memory access.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            is_store <= 1'b0;
            cur_addr <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                shadow_addr[i] <= '0;
                shadow_data[i] <= '0;
                lw_q[i]        <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_mem_op(op)) begin
                        is_store <= (op == OP_SW);
                        pending  <= active_mask;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            shadow_addr[i] <= addr_in[i*ADDR_W +: ADDR_W];
                            shadow_data[i] <= sw_data[i*DATA_W +: DATA_W];
                        end
                    end
                end
                ST_ISSUE: begin
                    if (req_fire) begin
                        if (is_store) begin
                            pending[cur_lane] <= 1'b0;
                        end else begin
                            cur_addr <= shadow_addr[cur_lane];
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        for (int j = 0; j < NUM_LANES; j++) begin
                            if (pending[j] && (shadow_addr[j] == cur_addr)) begin
                                pending[j] <= 1'b0;
                                lw_q[j]    <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        lw_out = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lw_out[i*DATA_W +: DATA_W] = lw_q[i];
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: a behavioural memory responder, a
// per-cycle compare process against a lane-level reference model, directed
// scenarios with literal expectations, and a randomized load/store mix.
module tb_mem_sequencer;
    import gpu_pkg::*;

    localparam int NL = 16;
    localparam int AW = 16;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           op;
    logic [NL-1:0]        active_mask;
    logic [NL*AW-1:0]     addr_in;
    logic [NL*DW-1:0]     sw_data;
    logic [NL*DW-1:0]     lw_out;
    logic                 stall;
    logic                 done;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_rsp_valid;
    logic [DW-1:0]        mem_rdata;

    always #5 clk = ~clk;

    mem_sequencer #(
        .NUM_LANES (NL),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .active_mask   (active_mask),
        .addr_in       (addr_in),
        .sw_data       (sw_data),
        .lw_out        (lw_out),
        .stall         (stall),
        .done          (done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic [DW-1:0] memArr [0:65535];
    logic [DW-1:0] lwModel [NL];
    req_t          expQ[$];
    req_t          reqLog[$];

    int passCount  = 0;
    int totalCount = 0;

    bit opBusy      = 1'b0;
    bit checkEn     = 1'b0;
    int cycleCount  = 0;
    int expLatency  = -1;
    int lastLatency = -1;
    int reqCount    = 0;
    int stuckCount  = 0;
    int holdReady   = 0;
    bit randomReady = 1'b0;
    bit spuriousEn  = 1'b0;
    bit suppressRsp = 1'b0;
    bit forceLateRsp = 1'b0;
    bit rspPending  = 1'b0;
    logic [AW-1:0] rspAddr = '0;
    bit   prevStuck = 1'b0;
    req_t prevReq;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        totalCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Memory responder: zero-wait, responds one cycle after a load handshake.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            mem_rdata     = DW'($urandom);
            if (rspPending && !suppressRsp) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = memArr[rspAddr];
            end else if (forceLateRsp || (spuriousEn && $urandom_range(0, 7) == 0)) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = 16'hDEAD;
            end
            rspPending   = 1'b0;
            forceLateRsp = 1'b0;
            if (holdReady > 0) begin
                mem_req_ready = 1'b0;
                holdReady--;
            end else if (randomReady) begin
                mem_req_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mem_req_ready = 1'b1;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_we) begin
                    memArr[mem_addr] = mem_wdata;
                end else begin
                    rspPending = 1'b1;
                    rspAddr    = mem_addr;
                end
            end
        end
    end

    // Per-cycle compare against the reference model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (checkEn) begin
                if (prevStuck) begin
                    checkOutput("req_hold_valid", 64'(mem_req_valid), 64'd1);
                    checkOutput("req_hold_fields", 64'({mem_we, mem_addr, mem_wdata}), 64'(prevReq));
                end
                prevStuck = mem_req_valid && !mem_req_ready;
                prevReq   = {mem_we, mem_addr, mem_wdata};
                if (prevStuck) stuckCount++;
                if (mem_req_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_req", 64'(mem_req_valid), 64'd0);
                    end else begin
                        checkOutput("req_fields", 64'({mem_we, mem_addr, mem_wdata}), 64'(expQ[0]));
                        if (mem_req_ready) begin
                            reqLog.push_back(expQ.pop_front());
                            reqCount++;
                        end
                    end
                end
                if (done) begin
                    checkOutput("done_expected", 64'(opBusy), 64'd1);
                    if (opBusy) begin
                        lastLatency = cycleCount;
                        if (expLatency >= 0) checkOutput("latency", 64'(cycleCount), 64'(expLatency));
                        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
                        for (int i = 0; i < NL; i++) begin
                            checkOutput("lw_out", 64'(lw_out[i*DW +: DW]), 64'(lwModel[i]));
                        end
                        opBusy = 1'b0;
                    end
                end else if (opBusy) begin
                    cycleCount++;
                end
                checkOutput("stall", 64'(stall), 64'(opBusy));
            end
        end
    end

    // Issues one instruction, builds the expected request sequence and load
    // results from lane-level rules, then waits (bounded) for completion.
    task automatic applyStimulus(input bit isStore, input logic [NL-1:0] mask,
                                 input logic [NL*AW-1:0] addrs, input logic [NL*DW-1:0] datas,
                                 input bit rndReady, input int hold);
        int  k;
        bit  seen;
        logic [AW-1:0] a;
        @(negedge clk);
        expQ.delete();
        reqLog.delete();
        reqCount   = 0;
        stuckCount = 0;
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) begin
                a = addrs[i*AW +: AW];
                if (isStore) begin
                    expQ.push_back({1'b1, a, datas[i*DW +: DW]});
                end else begin
                    seen = 1'b0;
                    foreach (expQ[q]) if (expQ[q].addr == a) seen = 1'b1;
                    if (!seen) expQ.push_back({1'b0, a, {DW{1'b0}}});
                    lwModel[i] = memArr[a];
                end
            end
        end
        expLatency  = (rndReady || hold > 0) ? -1 :
                      (isStore ? 2 + expQ.size() : 2 + 2 * expQ.size());
        randomReady = rndReady;
        holdReady   = hold;
        op          = isStore ? OP_SW : OP_LW;
        active_mask = mask;
        addr_in     = addrs;
        sw_data     = datas;
        cycleCount  = 0;
        opBusy      = 1'b1;
        @(negedge clk);
        op          = isStore ? OP_LW : OP_SW;
        active_mask = NL'($urandom);
        for (int i = 0; i < NL; i++) begin
            addr_in[i*AW +: AW] = AW'($urandom);
            sw_data[i*DW +: DW] = DW'($urandom);
        end
        @(negedge clk);
        op = 4'($urandom_range(0, 5));
        k = 0;
        while (opBusy && k < 3000) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (opBusy) begin
            checkOutput("timeout", 64'(opBusy), 64'd0);
            doReset();
        end
        randomReady = 1'b0;
    endtask

    task automatic doReset();
        checkEn     = 1'b0;
        suppressRsp = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        op    = 4'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        opBusy      = 1'b0;
        prevStuck   = 1'b0;
        suppressRsp = 1'b0;
        for (int i = 0; i < NL; i++) lwModel[i] = '0;
        @(negedge clk);
        checkEn = 1'b1;
    endtask

    initial begin
        logic [NL*AW-1:0] addrs;
        logic [NL*DW-1:0] datas;
        logic [NL-1:0]    mask;
        int               sel;

        for (int a = 0; a < 65536; a++) memArr[a] = DW'(a + 16'h100);
        for (int i = 0; i < NL; i++) lwModel[i] = '0;
        reset       = 1'b1;
        op          = 4'h0;
        active_mask = '0;
        addr_in     = '0;
        sw_data     = '0;
        repeat (3) @(negedge clk);
        #3;
        $display("[TB] reset state");
        checkOutput("rst_lw_out", 64'(lw_out == '0), 64'd1);
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        checkEn = 1'b1;

        $display("[TB] full-warp load, distinct addresses");
        for (int i = 0; i < NL; i++) addrs[i*AW +: AW] = AW'(i);
        applyStimulus(1'b0, 16'hFFFF, addrs, '0, 1'b0, 0);
        for (int i = 0; i < NL; i++) checkOutput("t1_lane", 64'(lw_out[i*DW +: DW]), 64'(16'h100 + i));
        checkOutput("t1_reqs", 64'(reqCount), 64'd16);
        checkOutput("t1_latency", 64'(lastLatency), 64'd34);

        $display("[TB] coalesced load");
        memArr[16'h0040] = 16'hBEEF;
        for (int i = 0; i < NL; i++) addrs[i*AW +: AW] = 16'h0040;
        applyStimulus(1'b0, 16'h00FF, addrs, '0, 1'b0, 0);
        checkOutput("t2_reqs", 64'(reqCount), 64'd1);
        checkOutput("t2_lane0", 64'(lw_out[0 +: DW]), 64'hBEEF);
        checkOutput("t2_lane7", 64'(lw_out[7*DW +: DW]), 64'hBEEF);
        checkOutput("t2_lane8", 64'(lw_out[8*DW +: DW]), 64'h108);
        checkOutput("t2_lane15", 64'(lw_out[15*DW +: DW]), 64'h10F);

        $display("[TB] store ordering");
        addrs = '0;
        datas = '0;
        addrs[0 +: AW]    = 16'h0010;
        addrs[2*AW +: AW] = 16'h0010;
        datas[0 +: DW]    = 16'hAAAA;
        datas[2*DW +: DW] = 16'h5555;
        applyStimulus(1'b1, 16'h0005, addrs, datas, 1'b0, 0);
        checkOutput("t3_reqs", 64'(reqCount), 64'd2);
        if (reqLog.size() == 2) begin
            checkOutput("t3_first", 64'(reqLog[0].data), 64'hAAAA);
            checkOutput("t3_second", 64'(reqLog[1].data), 64'h5555);
        end else begin
            checkOutput("t3_log_size", 64'(reqLog.size()), 64'd2);
        end
        checkOutput("t3_mem", 64'(memArr[16'h0010]), 64'h5555);

        $display("[TB] back-pressure");
        addrs = '0;
        addrs[0 +: AW]  = 16'h0020;
        addrs[AW +: AW] = 16'h0021;
        applyStimulus(1'b0, 16'h0003, addrs, '0, 1'b0, 6);
        checkOutput("t4_stuck", 64'(stuckCount), 64'd5);
        checkOutput("t4_lane1", 64'(lw_out[DW +: DW]), 64'h121);

        $display("[TB] empty mask");
        applyStimulus(1'b0, 16'h0000, addrs, '0, 1'b0, 0);
        checkOutput("t5_latency", 64'(lastLatency), 64'd2);
        checkOutput("t5_reqs", 64'(reqCount), 64'd0);

        $display("[TB] randomized mix");
        spuriousEn = 1'b1;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 7);
            mask = (sel == 0) ? '0 : (sel == 1) ? '1 : NL'($urandom);
            for (int i = 0; i < NL; i++) begin
                addrs[i*AW +: AW] = AW'(16'h0200 + $urandom_range(0, 7));
                datas[i*DW +: DW] = DW'($urandom);
            end
            applyStimulus(bit'($urandom_range(0, 1)), mask, addrs, datas,
                          bit'($urandom_range(0, 1)), 0);
        end
        spuriousEn = 1'b0;

        $display("[TB] reset during response wait");
        checkEn     = 1'b0;
        suppressRsp = 1'b1;
        for (int i = 0; i < NL; i++) addrs[i*AW +: AW] = AW'(16'h0300 + i);
        @(negedge clk);
        op          = OP_LW;
        active_mask = 16'h000F;
        addr_in     = addrs;
        @(negedge clk);
        op = 4'h0;
        @(negedge clk);
        #3;
        checkOutput("t7_stall_busy", 64'(stall), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        forceLateRsp = 1'b1;
        #3;
        checkOutput("t7_stall_idle", 64'(stall), 64'd0);
        checkOutput("t7_req_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("t7_lw_clear", 64'(lw_out == '0), 64'd1);
        @(negedge clk);
        #3;
        checkOutput("t7_late_rsp_lw", 64'(lw_out == '0), 64'd1);
        checkOutput("t7_late_rsp_req", 64'(mem_req_valid), 64'd0);
        checkOutput("t7_late_rsp_done", 64'(done), 64'd0);
        suppressRsp = 1'b0;
        expQ.delete();
        opBusy    = 1'b0;
        prevStuck = 1'b0;
        for (int i = 0; i < NL; i++) lwModel[i] = '0;
        checkEn = 1'b1;

        $display("[TB] recovery load");
        for (int i = 0; i < NL; i++) addrs[i*AW +: AW] = AW'(16'h0400 + $urandom_range(0, 3));
        applyStimulus(1'b0, 16'hF0F0, addrs, '0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
